// File: rtl/e203_exu_csr_arb.sv
// Shares the single CSR-file port between the EXU (requester 0) and the debug module
// (requester 1): one registered access cycle per accepted request, then a held response.
module e203_exu_csr_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_req_valid,
    output logic            r0_req_ready,
    input  logic [11:0]     r0_req_idx,
    input  logic            r0_req_rd,
    input  logic            r0_req_wr,
    input  logic [XLEN-1:0] r0_req_wdat,
    output logic            r0_rsp_valid,
    input  logic            r0_rsp_ready,
    output logic [XLEN-1:0] r0_rsp_rdat,
    output logic            r0_rsp_err,
    input  logic            r1_req_valid,
    output logic            r1_req_ready,
    input  logic [11:0]     r1_req_idx,
    input  logic            r1_req_rd,
    input  logic            r1_req_wr,
    input  logic [XLEN-1:0] r1_req_wdat,
    output logic            r1_rsp_valid,
    input  logic            r1_rsp_ready,
    output logic [XLEN-1:0] r1_rsp_rdat,
    output logic            r1_rsp_err,
    output logic            csr_ena,
    output logic            csr_rd_en,
    output logic            csr_wr_en,
    output logic [11:0]     csr_idx,
    output logic [XLEN-1:0] wbck_csr_dat,
    input  logic [XLEN-1:0] read_csr_dat,
    input  logic            csr_access_ilgl,
    input  logic            dbg_prio
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]      r_state;
    logic            r_last;
    logic            r_owner;
    logic            r_rd;
    logic            r_wr;
    logic [11:0]     r_idx;
    logic [XLEN-1:0] r_wdat;
    logic [XLEN-1:0] r_rdat;
    logic            r_err;

    logic w_idle;
    logic w_access;
    logic w_resp;
    logic w_grant0;
    logic w_grant1;
    logic w_hs;
    logic w_rsp_ready;

    assign w_idle   = (r_state == IDLE);
    assign w_access = (r_state == ACCESS);
    assign w_resp   = (r_state == RESP);

    // Requester 1 wins a conflict under debug priority or when requester 0 went last.
    assign w_grant1 = w_idle & r1_req_valid & (~r0_req_valid | dbg_prio | ~r_last);
    assign w_grant0 = w_idle & r0_req_valid & ~w_grant1;
    assign w_hs     = w_grant0 | w_grant1;

    assign w_rsp_ready = r_owner ? r1_rsp_ready : r0_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_hs) r_state <= ACCESS;
                ACCESS:  r_state <= RESP;
                RESP:    if (w_rsp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_idx   <= '0;
            r_wdat  <= '0;
        end else if (w_hs) begin
            r_last  <= w_grant1;
            r_owner <= w_grant1;
            r_rd    <= w_grant1 ? r1_req_rd   : r0_req_rd;
            r_wr    <= w_grant1 ? r1_req_wr   : r0_req_wr;
            r_idx   <= w_grant1 ? r1_req_idx  : r0_req_idx;
            r_wdat  <= w_grant1 ? r1_req_wdat : r0_req_wdat;
        end
    end

    // Read data and legality are only meaningful during the access strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdat <= '0;
            r_err  <= 1'b0;
        end else if (w_access) begin
            r_rdat <= r_rd ? read_csr_dat : '0;
            r_err  <= csr_access_ilgl;
        end
    end

    assign r0_req_ready = w_grant0;
    assign r1_req_ready = w_grant1;

    assign csr_ena      = w_access;
    assign csr_rd_en    = w_access & r_rd;
    assign csr_wr_en    = w_access & r_wr;
    assign csr_idx      = w_access ? r_idx  : '0;
    assign wbck_csr_dat = w_access ? r_wdat : '0;

    assign r0_rsp_valid = w_resp & ~r_owner;
    assign r1_rsp_valid = w_resp &  r_owner;
    assign r0_rsp_rdat  = r0_rsp_valid ? r_rdat : '0;
    assign r1_rsp_rdat  = r1_rsp_valid ? r_rdat : '0;
    assign r0_rsp_err   = r0_rsp_valid & r_err;
    assign r1_rsp_err   = r1_rsp_valid & r_err;

endmodule

// File: doc/e203_exu_csr_arb.md
# e203_exu_csr_arb

Two-requester arbiter and sequencer for the single CSR-file access port. It shares that port between the EXU CSR-instruction path (requester 0) and the debug-module abstract-command path (requester 1). Each accepted request becomes exactly one registered CSR access cycle, then a held response to the originating requester. The block sits between the requesters and the CSR file, so at most one CSR access is in flight at any time.

## Interface
- XLEN, default 32: CSR data width.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- r0_req_valid / r1_req_valid  in  1  request valid, per requester.
- r0_req_ready / r1_req_ready  out  1  request accepted when valid&ready.
- rN_req_idx  in  12  CSR index.
- rN_req_rd  in  1  read required.
- rN_req_wr  in  1  write required.
- rN_req_wdat  in  XLEN  write data.
- rN_rsp_valid  out  1  response valid.
- rN_rsp_ready  in  1  response accepted.
- rN_rsp_rdat  out  XLEN  read data captured during the access.
- rN_rsp_err  out  1  access was illegal.
- csr_ena  out  1  access strobe to the CSR file.
- csr_rd_en  out  1  read enable to the CSR file.
- csr_wr_en  out  1  write enable to the CSR file.
- csr_idx  out  12  CSR index to the CSR file.
- wbck_csr_dat  out  XLEN  write data to the CSR file.
- read_csr_dat  in  XLEN  combinational read data, valid in the same cycle as csr_ena.
- csr_access_ilgl  in  1  combinational illegal flag, valid in the same cycle as csr_ena.
- dbg_prio  in  1  when 1, requester 1 wins every conflict regardless of round-robin state.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - r0_req_ready = grant0 and r1_req_ready = grant1. Ready is combinational from the valids and the priority state.
  - Arbitration:
    - Only one valid: that requester is granted.
    - Both valid and dbg_prio=1: requester 1 is granted.
    - Both valid otherwise: the requester *not* granted last time is granted (round-robin).
    - The last-granted register resets to 1, so requester 0 wins the first conflict after reset.
  - On handshake:
    - Capture idx, rd, wr, wdat and the owner id.
    - Update last-granted.
    - Go to ACCESS.
  - No valid: stay in IDLE with all csr_* outputs 0.
- **ACCESS** (exactly one cycle)
  - csr_ena = 1.
  - csr_rd_en = captured rd; csr_wr_en = captured wr.
  - csr_idx and wbck_csr_dat come from the capture registers.
  - Capture read_csr_dat into the rdat register and csr_access_ilgl into the err register, then go to RESP.
  - If rd=0, the rdat register is loaded with 0.
  - If rd=0 and wr=0, the access still strobes csr_ena (legality check only).
- **RESP**
  - Only the owner's rsp_valid = 1.
  - rdat and err are driven from registers and are stable while valid.
  - On rsp_ready, go to IDLE.
  - No request is accepted during ACCESS or RESP; both req_ready = 0.
- Outputs:
  - Non-owner rsp_rdat / rsp_err are driven 0.
  - csr_* outputs are 0 outside ACCESS, including wbck_csr_dat and csr_idx.
- Reset values: state IDLE; all rsp_valid, csr_ena, csr_rd_en, csr_wr_en = 0; csr_idx, wbck_csr_dat, rdat and err registers = 0; last-granted = 1.

## Timing
- Request handshake in cycle N → csr_ena in N+1 → rsp_valid from N+2.
- With rsp_ready=1 in N+2, return to IDLE in N+3. Next handshake is possible in N+3, so peak throughput is 1 access per 3 cycles.
- rsp_valid stays high until rsp_ready; there is no timeout.
- A requester dropping valid in IDLE before handshake is permitted; nothing is captured.
- req_valid held during ACCESS/RESP is ignored and is re-arbitrated in the next IDLE.
- dbg_prio is sampled only in IDLE. Changing it mid-transaction does not affect the current owner.
- Reset asserted in any state:
  - Outputs clear immediately (asynchronously).
  - An in-flight response is lost.
  - An access in ACCESS is aborted, with csr_ena dropping with rst.

## Test plan
- **Single read.** r0 req idx=0x300, rd=1, wr=0 in cycle 1.
  - Cycle 2: csr_ena=1, csr_rd_en=1, csr_wr_en=0, csr_idx=0x300. Model drives read_csr_dat=0x1800.
  - Cycle 3: r0_rsp_valid=1, rdat=0x1800, err=0; r1_rsp_valid=0.
- **Conflict round-robin.** r0 and r1 both valid continuously, dbg_prio=0, rsp_ready=1.
  - Grants go r0, r1, r0, r1.
  - csr_ena pulses every 3 cycles, and csr_idx alternates between the two requesters' indices.
- **dbg_prio.** Both valid, dbg_prio=1 → r1 granted 3 times in a row; r0_req_ready never 1.
- **Response backpressure.** r1 write idx=0x7B2, wdat=0xDEADBEEF.
  - Cycle 2: csr_wr_en=1, wbck_csr_dat=0xDEADBEEF.
  - Hold r1_rsp_ready=0 for 5 cycles: rsp_valid stays 1, rdat/err stable, both req_ready=0.
  - Release: IDLE the next cycle.
- **Illegal access.** Model drives csr_access_ilgl=1 in the ACCESS cycle → owner rsp_err=1 in RESP; next access has err=0.
- **Reset mid-RESP.** Assert rst during RESP.
  - All outputs go to 0 without waiting for a clock.
  - After release, a new r0 request completes normally: r0 wins a simultaneous conflict because last-granted is reset to 1.
